// File: rtl/axi_mem_responder_if.sv
// AXI4 channel bundle between the core's 128-bit memory master port and axi_mem_responder.
// Signal names match the original S_AXI_* port list.
interface axi_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [7:0]              S_AXI_AWLEN;
  logic [1:0]              S_AXI_AWBURST;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WLAST;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [7:0]              S_AXI_ARLEN;
  logic [1:0]              S_AXI_ARBURST;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RLAST;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an on-chip word memory with a configurable read latency.
// Serves one transaction at a time; stands in for the MIG/DDR controller.
module axi_mem_responder #(
  parameter int unsigned ADDR_WIDTH   = 27,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned MEM_AW       = 12,
  parameter int unsigned READ_LATENCY = 4
) (
  input logic               clk,
  input logic               rst,
  axi_mem_responder_if.slave s_axi
);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 1 << MEM_AW;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RWAIT, RDATA} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [MEM_AW-1:0]     idx_q;
  logic [MEM_AW-1:0]     idx_next;
  logic [7:0]            len_q;
  logic                  incr_q;
  logic [8:0]            beat_q;
  logic [7:0]            wait_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic              aw_hs, ar_hs, w_hs, r_hs, last_beat;
  logic [MEM_AW-1:0] aw_idx, ar_idx;
  logic              unused_addr;

  assign aw_idx    = s_axi.S_AXI_AWADDR[MEM_AW+3:4];
  assign ar_idx    = s_axi.S_AXI_ARADDR[MEM_AW+3:4];
  assign last_beat = (beat_q == {1'b0, len_q});
  // FIXED holds the index; INCR and WRAP both step and roll over at the memory depth
  assign idx_next  = incr_q ? idx_q + MEM_AW'(1) : idx_q;

  assign aw_hs = (state_q == IDLE) && s_axi.S_AXI_AWVALID;
  assign ar_hs = (state_q == IDLE) && !s_axi.S_AXI_AWVALID && s_axi.S_AXI_ARVALID;
  assign w_hs  = (state_q == WDATA) && s_axi.S_AXI_WVALID;
  assign r_hs  = (state_q == RDATA) && s_axi.S_AXI_RREADY;

  assign s_axi.S_AXI_RDATA = rdata_q;
  assign s_axi.S_AXI_RRESP = '0;
  assign unused_addr = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d               = state_q;
    s_axi.S_AXI_AWREADY   = 1'b0;
    s_axi.S_AXI_ARREADY   = 1'b0;
    s_axi.S_AXI_WREADY    = 1'b0;
    s_axi.S_AXI_BVALID    = 1'b0;
    s_axi.S_AXI_BRESP     = '0;
    s_axi.S_AXI_RVALID    = 1'b0;
    s_axi.S_AXI_RLAST     = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi.S_AXI_AWREADY = 1'b1;
        s_axi.S_AXI_ARREADY = !s_axi.S_AXI_AWVALID;
        if (s_axi.S_AXI_AWVALID)      state_d = WDATA;
        else if (s_axi.S_AXI_ARVALID) state_d = (READ_LATENCY == 0) ? RDATA : RWAIT;
      end
      WDATA: begin
        s_axi.S_AXI_WREADY = 1'b1;
        if (s_axi.S_AXI_WVALID && last_beat) state_d = WRESP;
      end
      WRESP: begin
        s_axi.S_AXI_BVALID = 1'b1;
        s_axi.S_AXI_BRESP  = err_q ? 2'b10 : 2'b00;
        if (s_axi.S_AXI_BREADY) state_d = IDLE;
      end
      RWAIT: begin
        if (wait_q <= 8'd1) state_d = RDATA;
      end
      RDATA: begin
        s_axi.S_AXI_RVALID = 1'b1;
        s_axi.S_AXI_RLAST  = last_beat;
        if (s_axi.S_AXI_RREADY && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      len_q   <= '0;
      incr_q  <= 1'b0;
      beat_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (aw_hs) begin
        idx_q  <= aw_idx;
        len_q  <= s_axi.S_AXI_AWLEN;
        incr_q <= |s_axi.S_AXI_AWBURST;
        beat_q <= '0;
        err_q  <= 1'b0;
      end else if (ar_hs) begin
        idx_q  <= ar_idx;
        len_q  <= s_axi.S_AXI_ARLEN;
        incr_q <= |s_axi.S_AXI_ARBURST;
        beat_q <= '0;
        wait_q <= 8'(READ_LATENCY);
        // zero latency skips RWAIT, so the first word is fetched on the AR edge
        if (READ_LATENCY == 0) rdata_q <= mem[ar_idx];
      end
      if (w_hs) begin
        idx_q  <= idx_next;
        beat_q <= beat_q + 9'd1;
        err_q  <= err_q | (last_beat ? !s_axi.S_AXI_WLAST : s_axi.S_AXI_WLAST);
      end
      if (state_q == RWAIT) begin
        wait_q <= wait_q - 8'd1;
        if (wait_q <= 8'd1) rdata_q <= mem[idx_q];
      end
      if (r_hs && !last_beat) begin
        idx_q   <= idx_next;
        beat_q  <= beat_q + 9'd1;
        rdata_q <= mem[idx_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !rst) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (s_axi.S_AXI_WSTRB[i]) mem[idx_q][i*8 +: 8] <= s_axi.S_AXI_WDATA[i*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed vector table, corner sequences,
// and random transactions checked against a byte-level memory model.
module tb_axi_mem_responder;
  localparam int unsigned AW    = 27;
  localparam int unsigned DW    = 128;
  localparam int unsigned MAW   = 12;
  localparam int          LAT   = 3;
  localparam int          DEPTH = 1 << MAW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] ref_mem   [DEPTH];
  logic [15:0]  ref_known [DEPTH];
  logic [127:0] wdat [264];
  logic [15:0]  wstb [264];

  typedef struct {
    logic [26:0] wr_addr;
    logic [26:0] rd_addr;
    int          len;
    logic [1:0]  burst;
    int          wlast_at;
    logic [15:0] stb2;
    logic [1:0]  exp_bresp;
    int          exp_beats;
    int          mode;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int word_of(input logic [26:0] a, input int b, input logic [1:0] burst);
    int base;
    base = int'(a >> 4) % DEPTH;
    return (burst == 2'b00) ? base : (base + b) % DEPTH;
  endfunction

  function automatic logic [127:0] bmask(input logic [15:0] m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic model_write(input int w, input logic [127:0] d, input logic [15:0] s);
    for (int i = 0; i < 16; i++)
      if (s[i]) ref_mem[w][i*8 +: 8] = d[i*8 +: 8];
    ref_known[w] = ref_known[w] | s;
  endtask

  task automatic do_write(input logic [26:0] addr, input int len, input logic [1:0] burst,
                          input int wlast_at, output logic [1:0] bresp, output int nacc);
    int guard, cyc, hold;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWLEN   = 8'(len);
    bus.S_AXI_AWBURST = burst;
    bus.S_AXI_AWVALID = 1'b1;
    #1;
    guard = 0;
    while (!bus.S_AXI_AWREADY && guard < 50) begin step(); guard++; end
    check("aw_ready", 128'(bus.S_AXI_AWREADY), 128'(1));
    step();
    bus.S_AXI_AWVALID = 1'b0;
    cyc  = 0;
    nacc = 0;
    // keep offering beats until B shows up, so extra acceptance would be counted
    while (!bus.S_AXI_BVALID && cyc < len + 8) begin
      bus.S_AXI_WDATA  = wdat[cyc];
      bus.S_AXI_WSTRB  = wstb[cyc];
      bus.S_AXI_WLAST  = (cyc == wlast_at);
      bus.S_AXI_WVALID = 1'b1;
      #1;
      if (bus.S_AXI_WREADY) nacc++;
      step();
      cyc++;
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST  = 1'b0;
    check("b_timing", 128'(cyc), 128'(len + 1));
    check("w_ready_low_in_resp", 128'(bus.S_AXI_WREADY), 128'(0));
    for (int b = 0; b <= len; b++) model_write(word_of(addr, b, burst), wdat[b], wstb[b]);
    bresp = bus.S_AXI_BRESP;
    hold = int'($urandom_range(0, 3));
    for (int h = 0; h < hold; h++) begin
      step();
      check("b_hold", {126'd0, bus.S_AXI_BVALID, bus.S_AXI_BRESP == bresp}, 128'(3));
    end
    bus.S_AXI_BREADY = 1'b1;
    step();
    bus.S_AXI_BREADY = 1'b0;
    #1;
    check("b_done", {126'd0, bus.S_AXI_AWREADY, bus.S_AXI_BVALID}, 128'(2));
  endtask

  task automatic do_read(input logic [26:0] addr, input int len, input logic [1:0] burst,
                         input int mode, output int arwait);
    int cnt, b, k, guard, w;
    logic rr, stalled, hl;
    logic [127:0] hd, m;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARLEN   = 8'(len);
    bus.S_AXI_ARBURST = burst;
    bus.S_AXI_ARVALID = 1'b1;
    #1;
    arwait = 0;
    while (!bus.S_AXI_ARREADY && arwait < 50) begin step(); arwait++; end
    step();
    bus.S_AXI_ARVALID = 1'b0;
    cnt = 0;
    while (!bus.S_AXI_RVALID && cnt < 300) begin step(); cnt++; end
    check("r_latency", 128'(cnt), 128'(LAT));
    if (cnt >= 300) return;
    b = 0; k = 0; guard = 0; stalled = 1'b0; hd = '0; hl = 1'b0;
    while (b <= len && guard < 3000) begin
      if (mode == 0)      rr = 1'b1;
      else if (mode == 1) rr = (k % 3 == 0);
      else                rr = 1'($urandom_range(0, 1));
      k++;
      bus.S_AXI_RREADY = rr;
      check("r_valid", 128'(bus.S_AXI_RVALID), 128'(1));
      if (bus.S_AXI_RVALID !== 1'b1) break;
      if (stalled) begin
        check("r_stable_data", bus.S_AXI_RDATA, hd);
        check("r_stable_last", 128'(bus.S_AXI_RLAST), 128'(hl));
      end
      if (rr) begin
        w = word_of(addr, b, burst);
        m = bmask(ref_known[w]);
        if (m != '0) check("r_data", bus.S_AXI_RDATA & m, ref_mem[w] & m);
        check("r_last", 128'(bus.S_AXI_RLAST), 128'(b == len));
        b++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hd = bus.S_AXI_RDATA;
        hl = bus.S_AXI_RLAST;
      end
      step();
      guard++;
    end
    bus.S_AXI_RREADY = 1'b0;
    #1;
    check("r_done", {126'd0, bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, 128'(1));
  endtask

  task automatic fill_random(input logic [15:0] stb);
    for (int i = 0; i < 264; i++) begin
      wdat[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      wstb[i] = stb;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bresp;
    int nacc, arwait, len, wl;
    logic [26:0] addr;
    logic [1:0]  burst;

    for (int i = 0; i < DEPTH; i++) ref_known[i] = '0;
    vecs[0] = '{27'h0000100, 27'h0000100, 3,   2'b01, 3,   16'hFFFF, 2'b00, 4,   0};
    vecs[1] = '{27'h0000100, 27'h0000100, 3,   2'b01, 3,   16'h00FF, 2'b00, 4,   0};
    vecs[2] = '{27'h0000200, 27'h0000200, 2,   2'b01, 1,   16'hFFFF, 2'b10, 3,   0};
    vecs[3] = '{27'h0000300, 27'h0000300, 0,   2'b01, 99,  16'hFFFF, 2'b10, 1,   0};
    vecs[4] = '{27'h0000400, 27'h0000400, 3,   2'b00, 3,   16'hFFFF, 2'b00, 4,   2};
    vecs[5] = '{27'h0000500, 27'h0000500, 255, 2'b01, 255, 16'hFFFF, 2'b00, 256, 2};
    vecs[6] = '{27'h4000600, 27'h0000600, 1,   2'b10, 99,  16'hFFFF, 2'b10, 2,   1};

    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 128'(bus.S_AXI_AWREADY), 128'(1));
    check("rst_arready", 128'(bus.S_AXI_ARREADY), 128'(1));
    check("rst_valids", {125'd0, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 128'(0));
    check("rst_resps", {124'd0, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 128'(0));
    check("rst_rlast", 128'(bus.S_AXI_RLAST), 128'(0));
    check("rst_rdata", bus.S_AXI_RDATA, 128'(0));
    bus.S_AXI_AWVALID = 1'b1;
    #1;
    check("rst_arready_aw", 128'(bus.S_AXI_ARREADY), 128'(0));
    bus.S_AXI_AWVALID = 1'b0;
    rst = 1'b0;
    step();

    // single write then read
    fill_random(16'hFFFF);
    wdat[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
    do_write(27'h40, 0, 2'b01, 0, bresp, nacc);
    check("single_bresp", 128'(bresp), 128'(0));
    do_read(27'h40, 0, 2'b01, 0, arwait);

    // directed vector table
    for (int v = 0; v < 7; v++) begin
      fill_random(16'hFFFF);
      wstb[2] = vecs[v].stb2;
      do_write(vecs[v].wr_addr, vecs[v].len, vecs[v].burst, vecs[v].wlast_at, bresp, nacc);
      check($sformatf("vec%0d_bresp", v), 128'(bresp), 128'(vecs[v].exp_bresp));
      check($sformatf("vec%0d_beats", v), 128'(nacc), 128'(vecs[v].exp_beats));
      do_read(vecs[v].rd_addr, vecs[v].len, vecs[v].burst, vecs[v].mode, arwait);
    end

    // simultaneous AW and AR: write wins, read follows right after B
    fill_random(16'hFFFF);
    bus.S_AXI_ARADDR = 27'h40; bus.S_AXI_ARLEN = 8'd0; bus.S_AXI_ARBURST = 2'b01;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_AWADDR = 27'h40; bus.S_AXI_AWLEN = 8'd0; bus.S_AXI_AWBURST = 2'b01;
    bus.S_AXI_AWVALID = 1'b1;
    #1;
    check("collide_ready", {126'd0, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 128'(2));
    do_write(27'h40, 0, 2'b01, 0, bresp, nacc);
    do_read(27'h40, 0, 2'b01, 0, arwait);
    check("collide_ar_wait", 128'(arwait), 128'(0));

    // RREADY backpressure 1,0,0,...
    fill_random(16'hFFFF);
    do_write(27'h800, 7, 2'b01, 7, bresp, nacc);
    do_read(27'h800, 7, 2'b01, 1, arwait);

    // reset during RDATA
    bus.S_AXI_ARADDR = 27'h800; bus.S_AXI_ARLEN = 8'd7; bus.S_AXI_ARBURST = 2'b01;
    bus.S_AXI_ARVALID = 1'b1;
    #1;
    step();
    bus.S_AXI_ARVALID = 1'b0;
    len = 0;
    while (!bus.S_AXI_RVALID && len < 50) begin step(); len++; end
    check("rst_mid_rvalid_before", 128'(bus.S_AXI_RVALID), 128'(1));
    rst = 1'b1;
    step();
    check("rst_mid_rvalid", 128'(bus.S_AXI_RVALID), 128'(0));
    check("rst_mid_idle", {126'd0, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 128'(3));
    rst = 1'b0;
    step();
    do_read(27'h800, 7, 2'b01, 0, arwait);

    // INCR read wraps from the last word to word 0
    fill_random(16'hFFFF);
    do_write(27'h0, 0, 2'b01, 0, bresp, nacc);
    wdat[0] = wdat[1];
    do_write(27'hFFF0, 0, 2'b01, 0, bresp, nacc);
    do_read(27'hFFF0, 1, 2'b01, 0, arwait);

    // random traffic
    for (int t = 0; t < 40; t++) begin
      addr  = 27'(($urandom_range(0, 2047) << 16) | ($urandom_range(0, 63) << 4) | $urandom_range(0, 15));
      len   = int'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        fill_random(16'hFFFF);
        for (int i = 0; i < 264; i++) wstb[i] = 16'($urandom_range(0, 65535));
        wl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 16)) : len;
        do_write(addr, len, burst, wl, bresp, nacc);
        check("rand_bresp", 128'(bresp), 128'((wl != len) ? 2 : 0));
        check("rand_beats", 128'(nacc), 128'(len + 1));
      end else begin
        do_read(addr, len, burst, 2, arwait);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
